// File: rtl/apb_xbar.sv
// APB crossbar: INIT_N initiators share one target bus through a round-robin arbiter,
// with address decode, a per-access timeout, and registered single-cycle responses.
module apb_xbar #(
  parameter int unsigned INIT_N = 2,
  parameter int unsigned TGT_N  = 4,
  // Entry k lives at bits [32k+31:32k]; entry 0 is the rightmost word.
  parameter logic [TGT_N*32-1:0] TGT_BASE = {32'h8000_0000, 32'h1000_0000, 32'h0200_0000, 32'h0C00_0000},
  parameter logic [TGT_N*32-1:0] TGT_MASK = {32'h8000_0000, 32'hFFFF_F000, 32'hFFFF_0000, 32'hFC00_0000},
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INIT_N-1:0]     i_psel,
  input  logic [INIT_N-1:0]     i_penable,
  input  logic [INIT_N-1:0]     i_pwrite,
  input  logic [INIT_N*32-1:0]  i_paddr,
  input  logic [INIT_N*32-1:0]  i_pwdata,
  input  logic [INIT_N*4-1:0]   i_pwstrb,
  output logic [INIT_N-1:0]     i_pready,
  output logic [INIT_N-1:0]     i_pslverr,
  output logic [INIT_N*32-1:0]  i_prdata,
  output logic [TGT_N-1:0]      t_psel,
  output logic [TGT_N-1:0]      t_penable,
  output logic [31:0]           t_paddr,
  output logic                  t_pwrite,
  output logic [31:0]           t_pwdata,
  output logic [3:0]            t_pwstrb,
  input  logic [TGT_N-1:0]      t_pready,
  input  logic [TGT_N-1:0]      t_pslverr,
  input  logic [TGT_N*32-1:0]   t_prdata,
  output logic                  err_decode,
  output logic                  err_timeout
);
  localparam int unsigned IW = (INIT_N > 1) ? $clog2(INIT_N) : 1;
  localparam int unsigned TW = (TGT_N > 1) ? $clog2(TGT_N) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     gnt_q, gnt_d, last_q, last_d;
  logic [TW-1:0]     tgt_q, tgt_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       paddr_q, paddr_d, pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic [3:0]        pwstrb_q, pwstrb_d;
  logic [TGT_N-1:0]  psel_q, psel_d, penable_q, penable_d;
  logic [INIT_N-1:0] pready_q, pready_d, pslverr_q, pslverr_d;
  logic [31:0]       prdata_q [INIT_N];
  logic [31:0]       prdata_d [INIT_N];
  logic              err_dec_q, err_dec_d, err_to_q, err_to_d;

  logic [31:0] base_a [TGT_N];
  logic [31:0] mask_a [TGT_N];
  logic [31:0] tprdata_a [TGT_N];
  logic [31:0] ipaddr_a [INIT_N];
  logic [31:0] ipwdata_a [INIT_N];
  logic [3:0]  ipwstrb_a [INIT_N];

  logic          found, hit;
  logic [IW-1:0] cand, pick;
  logic [TW-1:0] tsel;
  logic [31:0]   addr;

  // Arbitration keys on psel alone; the initiator's enable phase carries no extra information here.
  logic unused_penable;
  assign unused_penable = ^i_penable;

  for (genvar k = 0; k < TGT_N; k++) begin : g_tgt
    assign base_a[k]    = TGT_BASE[32*k +: 32];
    assign mask_a[k]    = TGT_MASK[32*k +: 32];
    assign tprdata_a[k] = t_prdata[32*k +: 32];
  end

  for (genvar l = 0; l < INIT_N; l++) begin : g_lane
    assign ipaddr_a[l]           = i_paddr[32*l +: 32];
    assign ipwdata_a[l]          = i_pwdata[32*l +: 32];
    assign ipwstrb_a[l]          = i_pwstrb[4*l +: 4];
    assign i_prdata[32*l +: 32]  = prdata_q[l];
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pwstrb_d  = pwstrb_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pready_d  = '0;
    pslverr_d = '0;
    for (int unsigned l = 0; l < INIT_N; l++) prdata_d[l] = '0;
    err_dec_d = 1'b0;
    err_to_d  = 1'b0;
    found     = 1'b0;
    hit       = 1'b0;
    cand      = '0;
    pick      = last_q;
    tsel      = '0;
    addr      = '0;

    case (state_q)
      IDLE: begin
        for (int unsigned n = 1; n <= INIT_N; n++) begin
          cand = IW'((32'(last_q) + n) % INIT_N);
          if (!found && i_psel[cand]) begin
            found = 1'b1;
            pick  = cand;
          end
        end
        if (found) begin
          addr = ipaddr_a[pick];
          for (int unsigned k = 0; k < TGT_N; k++) begin
            if (!hit && ((addr & mask_a[TW'(k)]) == base_a[TW'(k)])) begin
              hit  = 1'b1;
              tsel = TW'(k);
            end
          end
          gnt_d    = pick;
          tgt_d    = tsel;
          pwrite_d = i_pwrite[pick];
          pwdata_d = ipwdata_a[pick];
          pwstrb_d = ipwstrb_a[pick];
          if (hit) begin
            paddr_d       = addr & ~mask_a[tsel];
            psel_d        = '0;
            psel_d[tsel]  = 1'b1;
            state_d       = SETUP;
          end else begin
            pready_d[pick]  = 1'b1;
            pslverr_d[pick] = 1'b1;
            err_dec_d       = 1'b1;
            state_d         = RESP;
          end
        end
      end
      SETUP: begin
        penable_d = psel_q;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // pready is tested first so a response on the final cycle beats the timeout.
        if (t_pready[tgt_q]) begin
          pready_d[gnt_q]  = 1'b1;
          pslverr_d[gnt_q] = t_pslverr[tgt_q];
          prdata_d[gnt_q]  = tprdata_a[tgt_q];
          psel_d           = '0;
          penable_d        = '0;
          state_d          = RESP;
        end else if (TIMEOUT != 0 && cnt_q == 32'(TIMEOUT - 1)) begin
          pready_d[gnt_q]  = 1'b1;
          pslverr_d[gnt_q] = 1'b1;
          err_to_d         = 1'b1;
          psel_d           = '0;
          penable_d        = '0;
          state_d          = RESP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RESP: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      last_q    <= IW'(INIT_N - 1);
      tgt_q     <= '0;
      cnt_q     <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pwstrb_q  <= '0;
      psel_q    <= '0;
      penable_q <= '0;
      pready_q  <= '0;
      pslverr_q <= '0;
      for (int unsigned l = 0; l < INIT_N; l++) prdata_q[l] <= '0;
      err_dec_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pwstrb_q  <= pwstrb_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      err_dec_q <= err_dec_d;
      err_to_q  <= err_to_d;
    end
  end

  assign i_pready    = pready_q;
  assign i_pslverr   = pslverr_q;
  assign t_psel      = psel_q;
  assign t_penable   = penable_q;
  assign t_paddr     = paddr_q;
  assign t_pwrite    = pwrite_q;
  assign t_pwdata    = pwdata_q;
  assign t_pwstrb    = pwstrb_q;
  assign err_decode  = err_dec_q;
  assign err_timeout = err_to_q;

endmodule
